// File: rtl/csa_pkg.sv
// Shared defaults and helpers for the pipelined carry-select adder.
// Optional feature macro used by the adder: PIPE_CSA_OVF_EN (adds port V).
package csa_pkg;

    // Default operand width and carry-select slice width.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLOCK = 8;

    // Number of pipeline stages, one per slice. Illegal shapes return 1 so
    // that widths stay positive; the top module rejects them separately.
    function automatic int csa_stages(input int width, input int block);
        int stages;
        if ((block > 0) && (width >= block) && ((width % block) == 0)) begin
            stages = width / block;
        end else begin
            stages = 1;
        end
        return stages;
    endfunction

    // Signed two's-complement overflow from the top bits of the effective
    // operands (B already inverted for subtraction) and of the sum.
    function automatic logic csa_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/csa_slice.sv
// One carry-select slice: two ripple adders precompute the sum for carry-in
// 0 and carry-in 1, and the real carry-in picks one. Purely combinational.
module csa_slice
    import csa_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    input  logic             cin_i,
    output logic [BLOCK-1:0] sum_o,
    output logic             cout_o
);

    logic [BLOCK:0]   c0_s;
    logic [BLOCK:0]   c1_s;
    logic [BLOCK-1:0] s0_s;
    logic [BLOCK-1:0] s1_s;

    // Dual ripple chains: one assuming carry-in 0, one assuming carry-in 1.
    always_comb begin
        c0_s    = '0;
        c1_s    = '0;
        s0_s    = '0;
        s1_s    = '0;
        c0_s[0] = 1'b0;
        c1_s[0] = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            s0_s[i]   = a_i[i] ^ b_i[i] ^ c0_s[i];
            c0_s[i+1] = (a_i[i] & b_i[i]) | (c0_s[i] & (a_i[i] ^ b_i[i]));
            s1_s[i]   = a_i[i] ^ b_i[i] ^ c1_s[i];
            c1_s[i+1] = (a_i[i] & b_i[i]) | (c1_s[i] & (a_i[i] ^ b_i[i]));
        end
    end

    // Carry-select mux driven by the incoming carry.
    always_comb begin
        if (cin_i) begin
            sum_o  = s1_s;
            cout_o = c1_s[BLOCK];
        end else begin
            sum_o  = s0_s;
            cout_o = c0_s[BLOCK];
        end
    end

endmodule

// File: rtl/pipe_csa_adder.sv
// Pipelined carry-select adder/subtractor: slice k of the operands is added
// in stage k using the carry registered by stage k-1. Unprocessed upper
// operand bits and finished lower sum bits ride along with each beat.
// A single global enable (en = !out_valid || out_ready) advances all stages.
// A beat presented in cycle c appears on the outputs in cycle c+STAGES.
// Optional feature macro: PIPE_CSA_OVF_EN adds the signed-overflow port V.
module pipe_csa_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef PIPE_CSA_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int STAGES = csa_stages(WIDTH, BLOCK);

    // Only whole slices are supported.
    if (((WIDTH % BLOCK) != 0) || (WIDTH < BLOCK)) begin : g_param_check
        $error("pipe_csa_adder: WIDTH must be a multiple of BLOCK and >= BLOCK");
    end

    logic             en_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin0_s;

    // Subtraction is A + ~B + 1; the external carry-in only matters for add.
    always_comb begin
        if (Sub) begin
            b_eff_s = ~B;
            cin0_s  = 1'b1;
        end else begin
            b_eff_s = B;
            cin0_s  = Cin;
        end
    end

    assign en_s     = !out_valid || out_ready;
    assign in_ready = en_s;

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        // Sum bits finished once this stage has run.
        localparam int DW = (k + 1) * BLOCK;

        logic [BLOCK-1:0] a_sl_s;
        logic [BLOCK-1:0] b_sl_s;
        logic [BLOCK-1:0] sum_sl_s;
        logic             cin_s;
        logic             cout_s;
        logic             vin_s;
        logic [DW-1:0]    sum_d_s;

        logic             valid_q;
        logic             carry_q;
        logic [DW-1:0]    sum_q;

        if (k == 0) begin : g_src
            assign a_sl_s  = A[BLOCK-1:0];
            assign b_sl_s  = b_eff_s[BLOCK-1:0];
            assign cin_s   = cin0_s;
            assign vin_s   = in_valid;
            assign sum_d_s = sum_sl_s;
        end else begin : g_src
            assign a_sl_s  = gen_stage[k-1].g_up.a_up_q[BLOCK-1:0];
            assign b_sl_s  = gen_stage[k-1].g_up.b_up_q[BLOCK-1:0];
            assign cin_s   = gen_stage[k-1].carry_q;
            assign vin_s   = gen_stage[k-1].valid_q;
            assign sum_d_s = {sum_sl_s, gen_stage[k-1].sum_q};
        end

        csa_slice #(
            .BLOCK (BLOCK)
        ) u_slice (
            .a_i    (a_sl_s),
            .b_i    (b_sl_s),
            .cin_i  (cin_s),
            .sum_o  (sum_sl_s),
            .cout_o (cout_s)
        );

        // Stage register: valid, slice carry-out and accumulated low sum bits.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (en_s) begin
                valid_q <= vin_s;
                carry_q <= cout_s;
                sum_q   <= sum_d_s;
            end
        end

        // Operand bits still waiting for later stages (absent in the last stage).
        if (k < STAGES - 1) begin : g_up
            localparam int UW = WIDTH - DW;

            logic [UW-1:0] a_up_d_s;
            logic [UW-1:0] b_up_d_s;
            logic [UW-1:0] a_up_q;
            logic [UW-1:0] b_up_q;

            if (k == 0) begin : g_usrc
                assign a_up_d_s = A[WIDTH-1:BLOCK];
                assign b_up_d_s = b_eff_s[WIDTH-1:BLOCK];
            end else begin : g_usrc
                assign a_up_d_s = gen_stage[k-1].g_up.a_up_q[UW+BLOCK-1:BLOCK];
                assign b_up_d_s = gen_stage[k-1].g_up.b_up_q[UW+BLOCK-1:BLOCK];
            end

            // Skew register carrying the unprocessed upper operand slices.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_up_q <= '0;
                    b_up_q <= '0;
                end else if (en_s) begin
                    a_up_q <= a_up_d_s;
                    b_up_q <= b_up_d_s;
                end
            end
        end

`ifdef PIPE_CSA_OVF_EN
        if (k == STAGES - 1) begin : g_last
            logic v_q;

            // Overflow is decided alongside the top slice so it lines up with S.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                end else if (en_s) begin
                    v_q <= csa_ovf(a_sl_s[BLOCK-1], b_sl_s[BLOCK-1], sum_sl_s[BLOCK-1]);
                end
            end
        end
`endif
    end

    assign out_valid = gen_stage[STAGES-1].valid_q;
    assign S         = gen_stage[STAGES-1].sum_q;
    assign Cout      = gen_stage[STAGES-1].carry_q;
`ifdef PIPE_CSA_OVF_EN
    assign V         = gen_stage[STAGES-1].g_last.v_q;
`endif

endmodule

// File: tb/tb_pipe_csa_adder.sv
// Directed self-checking bench for pipe_csa_adder with WIDTH=16, BLOCK=4.
// Overflow checks are built when PIPE_CSA_OVF_EN is defined.
module tb_pipe_csa_adder;

    localparam int W   = 16;
    localparam int BK  = 4;
    localparam int LAT = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] tb_a      = 16'h0000;
    logic [W-1:0] tb_b      = 16'h0000;
    logic         tb_cin    = 1'b0;
    logic         tb_sub    = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] S;
    logic         Cout;
`ifdef PIPE_CSA_OVF_EN
    logic         V;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pipe_csa_adder #(
        .WIDTH (W),
        .BLOCK (BK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (tb_a),
        .B         (tb_b),
        .Cin       (tb_cin),
        .Sub       (tb_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout)
`ifdef PIPE_CSA_OVF_EN
        ,
        .V         (V)
`endif
    );

    always #5 clk = ~clk;

    // Drive one beat and wait for its result; returns observed values and
    // the number of posedges from the accepting edge up to out_valid.
    task automatic run_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub,
                            output logic [W-1:0] s, output logic c,
                            output logic v, output int lat);
        @(negedge clk);
        tb_a = a; tb_b = b; tb_cin = cin; tb_sub = sub; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = S;
        c = Cout;
`ifdef PIPE_CSA_OVF_EN
        v = V;
`else
        v = 1'b0;
`endif
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (S !== 16'h0000) begin n_fail++; $display("FAIL reset_S got=%h exp=0000", S); end
        n_checks++; if (Cout !== 1'b0) begin n_fail++; $display("FAIL reset_Cout got=%b exp=0", Cout); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        logic [W-1:0] s; logic c; logic v; int lat;
        run_beat(16'h00FF, 16'h0001, 1'b0, 1'b0, s, c, v, lat);
        n_checks++; if (s !== 16'h0100) begin n_fail++; $display("FAIL add_ff_S got=%h exp=0100", s); end
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL add_ff_Cout got=%b exp=0", c); end
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL add_latency got=%0d exp=%0d", lat, LAT); end
        run_beat(16'hFFFF, 16'h0000, 1'b1, 1'b0, s, c, v, lat);
        n_checks++; if (s !== 16'h0000) begin n_fail++; $display("FAIL add_carry_chain_S got=%h exp=0000", s); end
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL add_carry_chain_Cout got=%b exp=1", c); end
        run_beat(16'h1234, 16'h4321, 1'b1, 1'b0, s, c, v, lat);
        n_checks++; if (s !== 16'h5556) begin n_fail++; $display("FAIL add_mixed_S got=%h exp=5556", s); end
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL add_mixed_Cout got=%b exp=0", c); end
    endtask

    task automatic test_sub();
        logic [W-1:0] s; logic c; logic v; int lat;
        run_beat(16'h0005, 16'h0007, 1'b1, 1'b1, s, c, v, lat);
        n_checks++; if (s !== 16'hFFFE) begin n_fail++; $display("FAIL sub_neg_S got=%h exp=FFFE", s); end
        n_checks++; if (c !== 1'b0) begin n_fail++; $display("FAIL sub_neg_Cout got=%b exp=0", c); end
        run_beat(16'h0007, 16'h0005, 1'b1, 1'b1, s, c, v, lat);
        n_checks++; if (s !== 16'h0002) begin n_fail++; $display("FAIL sub_pos_S got=%h exp=0002", s); end
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL sub_pos_Cout got=%b exp=1", c); end
        run_beat(16'h0007, 16'h0005, 1'b0, 1'b1, s, c, v, lat);
        n_checks++; if (s !== 16'h0002) begin n_fail++; $display("FAIL sub_cin_ignored_S got=%h exp=0002", s); end
        n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL sub_cin_ignored_Cout got=%b exp=1", c); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        logic         vs [6];
        logic [W-1:0] es [6];
        logic         ec [6];
        int tx = 0;
        int rx = 0;
        int cyc = 0;
        int stalls = 0;
        va[0] = 16'h0001; vb[0] = 16'h0001; vs[0] = 1'b0; es[0] = 16'h0002; ec[0] = 1'b0;
        va[1] = 16'h1000; vb[1] = 16'h1000; vs[1] = 1'b0; es[1] = 16'h2000; ec[1] = 1'b0;
        va[2] = 16'h8000; vb[2] = 16'h8000; vs[2] = 1'b0; es[2] = 16'h0000; ec[2] = 1'b1;
        va[3] = 16'hABCD; vb[3] = 16'h1111; vs[3] = 1'b0; es[3] = 16'hBCDE; ec[3] = 1'b0;
        va[4] = 16'h0010; vb[4] = 16'h0001; vs[4] = 1'b1; es[4] = 16'h000F; ec[4] = 1'b1;
        va[5] = 16'h00FF; vb[5] = 16'h0F01; vs[5] = 1'b0; es[5] = 16'h1000; ec[5] = 1'b0;
        while (rx < 6 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 7);
            if (tx < 6) begin
                in_valid = 1'b1; tb_a = va[tx]; tb_b = vb[tx]; tb_sub = vs[tx]; tb_cin = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
                n_checks++; if (S !== es[rx]) begin n_fail++; $display("FAIL b2b_stall_hold_S cyc=%0d got=%h exp=%h", cyc, S, es[rx]); end
            end else if (out_valid && out_ready) begin
                n_checks++; if (S !== es[rx]) begin n_fail++; $display("FAIL b2b_S beat=%0d got=%h exp=%h", rx, S, es[rx]); end
                n_checks++; if (Cout !== ec[rx]) begin n_fail++; $display("FAIL b2b_Cout beat=%0d got=%b exp=%b", rx, Cout, ec[rx]); end
                rx++;
            end
            if (in_valid && in_ready) tx++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (rx !== 6) begin n_fail++; $display("FAIL b2b_count got=%0d exp=6", rx); end
        n_checks++; if (stalls !== 3) begin n_fail++; $display("FAIL b2b_stall_cycles got=%0d exp=3", stalls); end
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_extra got=%b exp=0", out_valid); end
        end
    endtask

    task automatic test_reset_flight();
        logic [W-1:0] s; logic c; logic v; int lat;
        int flushed = 0;
        @(negedge clk);
        in_valid = 1'b1; tb_a = 16'h1111; tb_b = 16'h2222; tb_sub = 1'b0; tb_cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tb_a = 16'h3333; tb_b = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flight_before_reset got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flight_reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (S !== 16'h0000) begin n_fail++; $display("FAIL flight_reset_S got=%h exp=0000", S); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flight_in_ready got=%b exp=1", in_ready); end
        repeat (8) begin
            @(negedge clk);
            if (out_valid) flushed++;
        end
        n_checks++; if (flushed !== 0) begin n_fail++; $display("FAIL flight_flushed got=%0d exp=0", flushed); end
        run_beat(16'h0F0F, 16'h00F1, 1'b0, 1'b0, s, c, v, lat);
        n_checks++; if (s !== 16'h1000) begin n_fail++; $display("FAIL flight_next_S got=%h exp=1000", s); end
        n_checks++; if (lat !== LAT) begin n_fail++; $display("FAIL flight_next_latency got=%0d exp=%0d", lat, LAT); end
    endtask

`ifdef PIPE_CSA_OVF_EN
    task automatic test_overflow();
        logic [W-1:0] s; logic c; logic v; int lat;
        run_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, v, lat);
        n_checks++; if (s !== 16'h8000) begin n_fail++; $display("FAIL ovf_add_S got=%h exp=8000", s); end
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL ovf_add_V got=%b exp=1", v); end
        run_beat(16'h8000, 16'h0001, 1'b0, 1'b1, s, c, v, lat);
        n_checks++; if (s !== 16'h7FFF) begin n_fail++; $display("FAIL ovf_sub_S got=%h exp=7FFF", s); end
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL ovf_sub_V got=%b exp=1", v); end
        run_beat(16'h0005, 16'h0007, 1'b0, 1'b1, s, c, v, lat);
        n_checks++; if (v !== 1'b0) begin n_fail++; $display("FAIL ovf_none_V got=%b exp=0", v); end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_flight();
`ifdef PIPE_CSA_OVF_EN
        test_overflow();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_csa_adder.md
PIPE_CSA_ADDER -- requirements
Module: pipe_csa_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 SHALL have parameter BLOCK, default 8, carry-select slice width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state rises on its posedge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operand beat present.
REQ-006 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-007 SHALL have ports A and B, input, WIDTH each, the operands.
REQ-008 SHALL have port Cin, input, 1, carry-in; used only when Sub=0.
REQ-009 SHALL have port Sub, input, 1, mode: 0 = add, 1 = subtract.
REQ-010 SHALL have port out_valid, output, 1, result beat present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have ports S, output, WIDTH, and Cout, output, 1, the result and its carry-out.

Function
REQ-013 SHALL reject elaboration unless WIDTH mod BLOCK == 0 and WIDTH >= BLOCK; STAGES = WIDTH/BLOCK.
REQ-014 SHALL compute {Cout,S} = A + B + Cin when Sub=0, and A + ~B + 1 when Sub=1, with Cin ignored.
REQ-015 SHALL process slice k (bits k*BLOCK..k*BLOCK+BLOCK-1) in pipeline stage k, choosing between precomputed carry-0/carry-1 sums using the carry registered by stage k-1.
REQ-016 SHALL skew operands: unprocessed upper slices and finished lower sum bits travel with the beat in stage registers.
REQ-017 SHALL have latency of exactly STAGES cycles from accepting posedge to out_valid, with no stall.
REQ-018 SHALL sustain one beat per cycle when out_ready stays high.
REQ-019 SHALL use a global advance enable en = !out_valid || out_ready; in_ready = en; all stages shift only when en=1.
REQ-020 SHALL accept a beat only when in_valid && in_ready; in_valid=0 during en inserts a bubble (stage valid=0).
REQ-021 SHALL hold S, Cout and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL preserve beat order; no beat dropped or duplicated under any stall pattern.
REQ-023 SHALL, when STAGES=1, degenerate to one registered carry-select add with latency 1.

Reset
REQ-024 SHALL on rst_n low immediately clear every stage valid bit, out_valid, S, Cout (and V if present) to 0.
REQ-025 SHALL discard in-flight beats on reset mid-operation; none appear after release.
REQ-026 SHALL assert in_ready on the first cycle after rst_n release.

Configuration
REQ-027 SHALL, with macro PIPE_CSA_OVF_EN defined, add output V (1 bit), signed two's-complement overflow of the selected operation, aligned with S.
REQ-028 SHALL, without PIPE_CSA_OVF_EN, omit port V and its logic entirely; other behaviour identical.

Structure
REQ-029 SHALL place WIDTH/BLOCK defaults and the STAGES derivation function in shared package csa_pkg.
REQ-030 SHALL instantiate sub-module csa_slice (BLOCK-bit dual ripple adders plus carry mux, combinational) once per stage.

Verification (WIDTH=16, BLOCK=4, latency 4)
REQ-031 SHALL check A=0x00FF, B=0x0001, Cin=0, Sub=0 -> S=0x0100, Cout=0, out_valid exactly 4 cycles after accept.
REQ-032 SHALL check A=0xFFFF, B=0x0000, Cin=1, Sub=0 -> S=0x0000, Cout=1 (carry crosses all slices).
REQ-033 SHALL check A=0x0005, B=0x0007, Sub=1, Cin=1 -> S=0xFFFE, Cout=0; A=0x0007, B=0x0005 -> S=0x0002, Cout=1.
REQ-034 SHALL check 6 back-to-back beats with out_ready low for 3 cycles mid-stream -> in_ready low while stalled, all 6 results in order, S held stable during stall.
REQ-035 SHALL check rst_n pulsed low with 2 beats in flight -> out_valid=0 at once, no flushed result emitted, next accepted beat correct after 4 cycles.
REQ-036 SHALL, with PIPE_CSA_OVF_EN, check A=0x7FFF, B=0x0001, Sub=0, Cin=0 -> S=0x8000, V=1; A=0x8000, B=0x0001, Sub=1 -> S=0x7FFF, V=1.
